// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-style control unit: FETCH/DECODE/EXEC/WB sequencer with retire counter.
// Optional ILLEGAL_TRAP_EN: illegal ops raise sticky Trap and park in HALT until TrapClear.
module multicycle_control_unit #(
  parameter int ALUCTL_W    = 4,
  parameter int MUL_LATENCY = 3,
  parameter int COUNT_W     = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          Func,
  input  logic                InstrValid,
  output logic                InstrReady,
  output logic                ALUSrc,
  output logic                RegDst,
  output logic                RegWrite,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                Busy,
  output logic                Trap,
  input  logic                TrapClear,
  output logic [COUNT_W-1:0]  RetireCount
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t                state_q;
  logic [5:0]            op_q, func_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  legal_q;
  logic                  ready_q, busy_q, src_q, dst_q, rw_q, trap_q;
  logic [ALUCTL_W-1:0]   ctl_q;
  logic [COUNT_W-1:0]    retire_q;

  logic                  dec_legal, dec_src, dec_dst, dec_mul;
  logic [3:0]            dec_ctl;

  // Decode of the latched instruction; illegal encodings collapse to all-zero controls.
  always_comb begin
    dec_legal = 1'b1;
    dec_src   = 1'b0;
    dec_dst   = 1'b0;
    dec_mul   = 1'b0;
    dec_ctl   = 4'b0000;
    if (op_q == 6'b000000) begin
      dec_dst = 1'b1;
      case (func_q)
        6'b100000: dec_ctl = 4'b0010;
        6'b100010: dec_ctl = 4'b0110;
        6'b100100: dec_ctl = 4'b0000;
        6'b100101: dec_ctl = 4'b0001;
        6'b100110: dec_ctl = 4'b0011;
        6'b101010: dec_ctl = 4'b0111;
        6'b011000: begin dec_ctl = 4'b1000; dec_mul = 1'b1; end
        default:   dec_legal = 1'b0;
      endcase
    end else begin
      dec_src = 1'b1;
      case (op_q)
        6'b001000: dec_ctl = 4'b0010;
        6'b001100: dec_ctl = 4'b0000;
        6'b001101: dec_ctl = 4'b0001;
        6'b001110: dec_ctl = 4'b0011;
        default:   dec_legal = 1'b0;
      endcase
    end
    if (!dec_legal) begin
      dec_src = 1'b0;
      dec_dst = 1'b0;
      dec_mul = 1'b0;
      dec_ctl = 4'b0000;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      func_q   <= '0;
      cnt_q    <= '0;
      legal_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      src_q    <= 1'b0;
      dst_q    <= 1'b0;
      rw_q     <= 1'b0;
      ctl_q    <= '0;
      trap_q   <= 1'b0;
      retire_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (InstrValid) begin
          op_q    <= Opcode;
          func_q  <= Func;
          state_q <= S_DECODE;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        S_DECODE: begin
          src_q   <= dec_src;
          dst_q   <= dec_dst;
          ctl_q   <= ALUCTL_W'(dec_ctl);
          legal_q <= dec_legal;
`ifdef ILLEGAL_TRAP_EN
          if (!dec_legal) begin
            trap_q  <= 1'b1;
            state_q <= S_HALT;
          end else
`endif
          begin
            state_q <= S_EXEC;
            cnt_q   <= dec_mul ? CNT_W'(MUL_LATENCY - 1) : '0;
          end
        end
        S_EXEC: if (cnt_q == '0) begin
          state_q <= S_WB;
          rw_q    <= legal_q;
          if (legal_q) retire_q <= retire_q + 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        S_WB: begin
          rw_q    <= 1'b0;
          state_q <= S_FETCH;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT: if (TrapClear) begin
          trap_q  <= 1'b0;
          state_q <= S_FETCH;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
`endif
        default: begin
          rw_q    <= 1'b0;
          state_q <= S_FETCH;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign Trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = TrapClear ^ trap_q;
  assign Trap = 1'b0;
`endif

  assign InstrReady  = ready_q;
  assign Busy        = busy_q;
  assign ALUSrc      = src_q;
  assign RegDst      = dst_q;
  assign RegWrite    = rw_q;
  assign ALUControl  = ctl_q;
  assign RetireCount = retire_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: decode table vectors, hand sequences, and random
// traffic checked every cycle against an instruction-timeline reference model.
module tb_multicycle_control_unit;

  localparam int ML = 3;
  localparam int CW = 2;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          Clk, Rst_n, InstrValid, TrapClear;
  logic [5:0]    Opcode, Func;
  logic          InstrReady, ALUSrc, RegDst, RegWrite, Busy, Trap;
  logic [3:0]    ALUControl;
  logic [CW-1:0] RetireCount;

  multicycle_control_unit #(.ALUCTL_W(4), .MUL_LATENCY(ML), .COUNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Func(Func), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .ALUSrc(ALUSrc), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .Busy(Busy), .Trap(Trap), .TrapClear(TrapClear),
    .RetireCount(RetireCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         anyfn;
    bit         legal;
    bit         src;
    bit         dst;
    logic [3:0] ctl;
    int         lat;
  } vec_t;

  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;

  // Reference model: age counts cycles since the accepting edge of the current instruction.
  int            m_age;
  bit            m_halt, m_trap, m_rw, m_src, m_dst;
  logic [3:0]    m_ctl;
  logic [CW-1:0] m_cnt;
  bit            p_legal, p_src, p_dst;
  logic [3:0]    p_ctl;
  int            p_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_age = -1; m_halt = 0; m_trap = 0; m_rw = 0;
    m_src = 0; m_dst = 0; m_ctl = 4'd0; m_cnt = '0;
  endtask

  task automatic lookup(input logic [5:0] op, input logic [5:0] fn);
    p_legal = 0; p_src = 0; p_dst = 0; p_ctl = 4'd0; p_lat = 1;
    foreach (tbl[i])
      if (tbl[i].legal && tbl[i].op == op && (tbl[i].anyfn || tbl[i].fn == fn)) begin
        p_legal = 1; p_src = tbl[i].src; p_dst = tbl[i].dst;
        p_ctl = tbl[i].ctl; p_lat = tbl[i].lat;
      end
  endtask

  task automatic model_edge();
    if (!Rst_n) begin
      model_reset();
    end else if (m_halt) begin
      if (TrapClear) begin m_halt = 0; m_trap = 0; end
    end else if (m_age < 0) begin
      if (InstrValid) begin lookup(Opcode, Func); m_age = 1; end
    end else begin
      m_age++;
      m_rw = 0;
      if (m_age == 2) begin
        m_src = p_src; m_dst = p_dst; m_ctl = p_ctl;
        if (!p_legal && TRAP_EN) begin m_trap = 1; m_halt = 1; m_age = -1; end
      end
      if (m_age == p_lat + 2) begin
        m_rw = p_legal;
        if (p_legal) m_cnt = m_cnt + 1'b1;
      end else if (m_age == p_lat + 3) begin
        m_age = -1;
      end
    end
  endtask

  task automatic compare_all();
    bit rdy;
    rdy = (m_age < 0) && !m_halt;
    chk("InstrReady", 32'(InstrReady), 32'(rdy));
    chk("Busy", 32'(Busy), 32'(!rdy));
    chk("ALUSrc", 32'(ALUSrc), 32'(m_src));
    chk("RegDst", 32'(RegDst), 32'(m_dst));
    chk("RegWrite", 32'(RegWrite), 32'(m_rw));
    chk("ALUControl", 32'(ALUControl), 32'(m_ctl));
    chk("Trap", 32'(Trap), 32'(m_trap));
    chk("RetireCount", 32'(RetireCount), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Issue one instruction from FETCH and run until the unit is idle again.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, output int rw_at);
    Opcode = op; Func = fn; InstrValid = 1;
    tick();
    chk("accept", 32'(Busy), 32'd1);
    InstrValid = 0;
    Opcode = 6'($urandom_range(0, 63));
    rw_at = 0;
    for (int k = 2; k <= 20; k++) begin
      if (m_halt) TrapClear = 1;
      tick();
      TrapClear = 0;
      if (RegWrite === 1'b1 && rw_at == 0) rw_at = k;
      if (Busy === 1'b0) return;
    end
    chk("idle timeout", 32'(Busy), 32'd0);
  endtask

  task automatic pick(output logic [5:0] op, output logic [5:0] fn);
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) begin
      r = $urandom_range(0, 10);
      op = tbl[r].op;
      fn = tbl[r].anyfn ? 6'($urandom_range(0, 63)) : tbl[r].fn;
    end else begin
      op = (r == 8) ? 6'd0 : 6'($urandom_range(0, 63));
      fn = 6'($urandom_range(0, 63));
    end
  endtask

  initial begin
    int         rw_at, a1, a2;
    bit         was_ready;
    logic [CW-1:0] c0;
    logic [5:0] op, fn;
    int         wrapx[5];

    tbl[0]  = '{6'b000000, 6'b100000, 0, 1, 0, 1, 4'b0010, 1};
    tbl[1]  = '{6'b000000, 6'b100010, 0, 1, 0, 1, 4'b0110, 1};
    tbl[2]  = '{6'b000000, 6'b100100, 0, 1, 0, 1, 4'b0000, 1};
    tbl[3]  = '{6'b000000, 6'b100101, 0, 1, 0, 1, 4'b0001, 1};
    tbl[4]  = '{6'b000000, 6'b100110, 0, 1, 0, 1, 4'b0011, 1};
    tbl[5]  = '{6'b000000, 6'b101010, 0, 1, 0, 1, 4'b0111, 1};
    tbl[6]  = '{6'b000000, 6'b011000, 0, 1, 0, 1, 4'b1000, ML};
    tbl[7]  = '{6'b001000, 6'b000000, 1, 1, 1, 0, 4'b0010, 1};
    tbl[8]  = '{6'b001100, 6'b000000, 1, 1, 1, 0, 4'b0000, 1};
    tbl[9]  = '{6'b001101, 6'b000000, 1, 1, 1, 0, 4'b0001, 1};
    tbl[10] = '{6'b001110, 6'b000000, 1, 1, 1, 0, 4'b0011, 1};
    tbl[11] = '{6'b000000, 6'b111111, 0, 0, 0, 0, 4'b0000, 1};
    tbl[12] = '{6'b111111, 6'b000000, 0, 0, 0, 0, 4'b0000, 1};
    wrapx = '{1, 2, 3, 0, 1};

    Rst_n = 0; InstrValid = 0; TrapClear = 0; Opcode = 6'd0; Func = 6'd0;
    model_reset();
    tick(); tick();
    chk("reset InstrReady", 32'(InstrReady), 32'd1);
    chk("reset Busy", 32'(Busy), 32'd0);
    @(negedge Clk); Rst_n = 1;
    tick();

    // Counter wrap with a 2-bit RetireCount.
    for (int j = 0; j < 5; j++) begin
      run_instr(6'b000000, 6'b100000, rw_at);
      chk("wrap count", 32'(RetireCount), 32'(wrapx[j]));
    end

    // Decode table, one instruction at a time.
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, rw_at);
      chk($sformatf("vec%0d ALUSrc", i), 32'(ALUSrc), 32'(tbl[i].src));
      chk($sformatf("vec%0d RegDst", i), 32'(RegDst), 32'(tbl[i].dst));
      chk($sformatf("vec%0d ALUControl", i), 32'(ALUControl), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d RegWrite latency", i), 32'(rw_at),
          tbl[i].legal ? 32'(tbl[i].lat + 2) : 32'd0);
    end

    // ORI then ADDI back-to-back with InstrValid held high.
    c0 = m_cnt;
    Opcode = 6'b001101; Func = 6'($urandom_range(0, 63)); InstrValid = 1;
    tick();
    a1 = 0; a2 = -1;
    Opcode = 6'b001000;
    for (int k = 1; k <= 12; k++) begin
      was_ready = InstrReady;
      if (was_ready) begin
        chk("b2b ori ALUControl", 32'(ALUControl), 32'b0001);
        chk("b2b ori ALUSrc", 32'(ALUSrc), 32'd1);
      end
      tick();
      if (was_ready) begin a2 = k; break; end
    end
    chk("b2b accept spacing", 32'(a2 - a1), 32'd4);
    InstrValid = 0;
    for (int k = 0; k < 10 && Busy === 1'b1; k++) tick();
    chk("b2b addi ALUControl", 32'(ALUControl), 32'b0010);
    chk("b2b addi RegDst", 32'(RegDst), 32'd0);
    chk("b2b retire", 32'(RetireCount), 32'(c0 + 2'd2));

    // Reset in the middle of a MULT's EXEC phase.
    c0 = m_cnt;
    Opcode = 6'b000000; Func = 6'b011000; InstrValid = 1;
    tick();
    InstrValid = 0;
    tick(); tick();
    chk("mult ALUControl", 32'(ALUControl), 32'b1000);
    @(negedge Clk); Rst_n = 0; #1;
    model_reset();
    compare_all();
    chk("midrst ALUControl", 32'(ALUControl), 32'd0);
    chk("midrst InstrReady", 32'(InstrReady), 32'd1);
    chk("midrst RetireCount", 32'(RetireCount), 32'd0);
    tick();
    @(negedge Clk); Rst_n = 1;
    for (int k = 0; k < 6; k++) tick();

    // Random traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 2000; c++) begin
      pick(op, fn);
      Opcode = op; Func = fn;
      InstrValid = ($urandom_range(0, 2) != 0);
      TrapClear = ($urandom_range(0, 4) == 0);
      Rst_n = ($urandom_range(0, 399) != 0);
      tick();
      Rst_n = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
